uart_fifo_param: RTL and testbench

//  Parametrised synchronous FIFO for the UART TX/RX datapaths; next generation of the fixed 8x32 tx FIFO.

---
 rtl/uart_fifo_param_if.sv | 32 +++
 rtl/uart_fifo_param.sv | 116 +++++++++++
 tb/tb_uart_fifo_param.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_param_if.sv
// Handshake/status bundle between a byte producer/consumer and uart_fifo_param.
// The FIFO side uses the slave modport; the producer/consumer side uses master.
interface uart_fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              fifo_flush;
    logic              fifo_wren;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_rden;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_aempty;
    logic              fifo_afull;
    logic [ADDR_W:0]   fifo_level;
    logic              fifo_clr_err;
    logic              fifo_over;
    logic              fifo_under;

    modport master (
        output fifo_flush, fifo_wren, fifo_wr_data, fifo_rden, fifo_clr_err,
        input  fifo_rd_data, fifo_empty, fifo_full, fifo_aempty, fifo_afull,
               fifo_level, fifo_over, fifo_under
    );

    modport slave (
        input  fifo_flush, fifo_wren, fifo_wr_data, fifo_rden, fifo_clr_err,
        output fifo_rd_data, fifo_empty, fifo_full, fifo_aempty, fifo_afull,
               fifo_level, fifo_over, fifo_under
    );
endinterface

// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART TX/RX datapaths: all DEPTH entries usable,
// level/threshold flags, sticky over/underflow errors, flush, registered or show-ahead read.
module uart_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned AFULL_TH  = 28,
    parameter int unsigned AEMPTY_TH = 2,
    parameter int unsigned FWFT      = 0
) (
    input  logic              sclk,
    input  logic              rst,
    uart_fifo_param_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LVL_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt;
    logic              empty_q;
    logic              full_q;
    logic              aempty_q;
    logic              afull_q;
    logic              over_q;
    logic              under_q;
    logic              rd_ok;
    logic              wr_ok;
    logic              over_set;
    logic              under_set;

    // Accept decisions use only registered state; flush suppresses both sides.
    always_comb begin
        rd_ok     = 1'b0;
        wr_ok     = 1'b0;
        over_set  = 1'b0;
        under_set = 1'b0;
        level_nxt = level;
        if (!bus.fifo_flush) begin
            rd_ok     = bus.fifo_rden & ~empty_q;
            wr_ok     = bus.fifo_wren & (~full_q | rd_ok);
            over_set  = bus.fifo_wren & ~wr_ok;
            under_set = bus.fifo_rden & ~rd_ok;
            if (wr_ok && !rd_ok) begin
                level_nxt = level + LVL_W'(1);
            end else if (rd_ok && !wr_ok) begin
                level_nxt = level - LVL_W'(1);
            end
        end else begin
            level_nxt = '0;
        end
    end

    // Pointers, level, and flags registered as decodes of the next level.
    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            over_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            if (bus.fifo_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            level    <= level_nxt;
            empty_q  <= (level_nxt == '0);
            full_q   <= (level_nxt == LVL_W'(DEPTH));
            aempty_q <= (level_nxt <= LVL_W'(AEMPTY_TH));
            afull_q  <= (level_nxt >= LVL_W'(AFULL_TH));
            // Set wins over clear.
            over_q   <= over_set  | (over_q  & ~bus.fifo_clr_err);
            under_q  <= under_set | (under_q & ~bus.fifo_clr_err);
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge sclk) begin
        if (wr_ok && !rst) begin
            mem[wr_ptr] <= bus.fifo_wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.fifo_rd_data = mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            always_ff @(posedge sclk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else if (rd_ok) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
            assign bus.fifo_rd_data = rd_data_q;
        end
    endgenerate

    assign bus.fifo_empty  = empty_q;
    assign bus.fifo_full   = full_q;
    assign bus.fifo_aempty = aempty_q;
    assign bus.fifo_afull  = afull_q;
    assign bus.fifo_level  = level;
    assign bus.fifo_over   = over_q;
    assign bus.fifo_under  = under_q;
endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: registered-read instance against a queue scoreboard,
// plus a show-ahead instance for FWFT and flush behaviour.
module tb_uart_fifo_param;
    logic sclk = 1'b0;
    logic rst  = 1'b1;
    always #5 sclk = ~sclk;

    uart_fifo_param_if #(.DATA_W(8), .ADDR_W(5)) bus0 ();
    uart_fifo_param_if #(.DATA_W(8), .ADDR_W(5)) bus1 ();

    uart_fifo_param #(.DATA_W(8), .ADDR_W(5), .AFULL_TH(28), .AEMPTY_TH(2), .FWFT(0))
        dut_reg (.sclk(sclk), .rst(rst), .bus(bus0));
    uart_fifo_param #(.DATA_W(8), .ADDR_W(5), .AFULL_TH(28), .AEMPTY_TH(2), .FWFT(1))
        dut_fwft (.sclk(sclk), .rst(rst), .bus(bus1));

    int vectors = 0;
    int errors  = 0;

    logic [7:0] q[$];
    logic [7:0] exp_rd   = 8'h00;
    bit         m_over   = 1'b0;
    bit         m_under  = 1'b0;
    bit         read_done;

    task automatic idle_bus(input bit sel);
        if (!sel) begin
            bus0.fifo_wren = 1'b0; bus0.fifo_rden = 1'b0; bus0.fifo_wr_data = 8'h00;
            bus0.fifo_clr_err = 1'b0; bus0.fifo_flush = 1'b0;
        end else begin
            bus1.fifo_wren = 1'b0; bus1.fifo_rden = 1'b0; bus1.fifo_wr_data = 8'h00;
            bus1.fifo_clr_err = 1'b0; bus1.fifo_flush = 1'b0;
        end
    endtask

    // One cycle of stimulus on the registered instance; scoreboard updated with predicted accepts.
    task automatic drive(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit rok, wok;
        rok = rd && (q.size() != 0);
        wok = wr && ((q.size() < 32) || rok);
        bus0.fifo_wren = wr; bus0.fifo_wr_data = d; bus0.fifo_rden = rd;
        bus0.fifo_clr_err = clr; bus0.fifo_flush = 1'b0;
        @(posedge sclk); #1;
        if (rok) exp_rd = q.pop_front();
        if (wok) q.push_back(d);
        m_over  = (wr && !wok) ? 1'b1 : (clr ? 1'b0 : m_over);
        m_under = (rd && !rok) ? 1'b1 : (clr ? 1'b0 : m_under);
        read_done = rok;
        idle_bus(1'b0);
    endtask

    task automatic test_reset();
        idle_bus(1'b0); idle_bus(1'b1);
        rst = 1'b1;
        repeat (2) @(posedge sclk);
        #1 rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (bus0.fifo_rd_data !== 8'h11) begin
            errors++; $display("FAIL pre_reset_rd_data got %h want 11", bus0.fifo_rd_data);
        end
        rst = 1'b1;
        bus0.fifo_wren = 1'b1; bus0.fifo_wr_data = 8'hEE; bus0.fifo_rden = 1'b1;
        @(posedge sclk); #1;
        rst = 1'b0; idle_bus(1'b0);
        q.delete(); exp_rd = 8'h00; m_over = 1'b0; m_under = 1'b0;
        vectors += 8;
        if (bus0.fifo_level !== 6'd0) begin errors++; $display("FAIL rst_level got %0d want 0", bus0.fifo_level); end
        if (bus0.fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", bus0.fifo_empty); end
        if (bus0.fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", bus0.fifo_full); end
        if (bus0.fifo_aempty !== 1'b1) begin errors++; $display("FAIL rst_aempty got %b want 1", bus0.fifo_aempty); end
        if (bus0.fifo_afull !== 1'b0) begin errors++; $display("FAIL rst_afull got %b want 0", bus0.fifo_afull); end
        if (bus0.fifo_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", bus0.fifo_rd_data); end
        if (bus0.fifo_over !== 1'b0) begin errors++; $display("FAIL rst_over got %b want 0", bus0.fifo_over); end
        if (bus0.fifo_under !== 1'b0) begin errors++; $display("FAIL rst_under got %b want 0", bus0.fifo_under); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            vectors += 3;
            if (bus0.fifo_level !== 6'(q.size()))
                begin errors++; $display("FAIL fill_level got %0d want %0d", bus0.fifo_level, q.size()); end
            if (bus0.fifo_afull !== (q.size() >= 28))
                begin errors++; $display("FAIL fill_afull got %b at level %0d", bus0.fifo_afull, q.size()); end
            if (bus0.fifo_full !== (q.size() == 32))
                begin errors++; $display("FAIL fill_full got %b at level %0d", bus0.fifo_full, q.size()); end
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        vectors += 2;
        if (bus0.fifo_over !== 1'b1) begin errors++; $display("FAIL overflow_flag got %b want 1", bus0.fifo_over); end
        if (bus0.fifo_level !== 6'd32) begin errors++; $display("FAIL overflow_level got %0d want 32", bus0.fifo_level); end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors += 3;
            if (bus0.fifo_rd_data !== exp_rd || exp_rd !== 8'(i))
                begin errors++; $display("FAIL drain_data got %h want %h", bus0.fifo_rd_data, 8'(i)); end
            if (bus0.fifo_aempty !== (q.size() <= 2))
                begin errors++; $display("FAIL drain_aempty got %b at level %0d", bus0.fifo_aempty, q.size()); end
            if (bus0.fifo_empty !== (q.size() == 0))
                begin errors++; $display("FAIL drain_empty got %b at level %0d", bus0.fifo_empty, q.size()); end
        end
    endtask

    task automatic test_full_rw();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        vectors += 3;
        if (bus0.fifo_level !== 6'd32) begin errors++; $display("FAIL full_rw_level got %0d want 32", bus0.fifo_level); end
        if (bus0.fifo_over !== 1'b0) begin errors++; $display("FAIL full_rw_over got %b want 0", bus0.fifo_over); end
        if (bus0.fifo_rd_data !== 8'h40) begin errors++; $display("FAIL full_rw_data got %h want 40", bus0.fifo_rd_data); end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (bus0.fifo_rd_data !== exp_rd)
                begin errors++; $display("FAIL full_rw_drain got %h want %h", bus0.fifo_rd_data, exp_rd); end
        end
        vectors++;
        if (bus0.fifo_rd_data !== 8'hA5) begin errors++; $display("FAIL full_rw_last got %h want a5", bus0.fifo_rd_data); end
    endtask

    task automatic test_empty_rw();
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        vectors += 2;
        if (bus0.fifo_level !== 6'd1) begin errors++; $display("FAIL empty_rw_level got %0d want 1", bus0.fifo_level); end
        if (bus0.fifo_under !== 1'b1) begin errors++; $display("FAIL empty_rw_under got %b want 1", bus0.fifo_under); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (bus0.fifo_under !== 1'b0) begin errors++; $display("FAIL clr_under got %b want 0", bus0.fifo_under); end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (bus0.fifo_rd_data !== 8'h3C) begin errors++; $display("FAIL empty_rw_data got %h want 3c", bus0.fifo_rd_data); end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        vectors += 2;
        if (bus0.fifo_under !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b want 1", bus0.fifo_under); end
        if (bus0.fifo_rd_data !== 8'h3C) begin errors++; $display("FAIL rejected_rd_hold got %h want 3c", bus0.fifo_rd_data); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        bit wr, rd;
        for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (q.size() <= 10)      begin wr = 1'b1; rd = 1'($urandom_range(0, 1)); end
            else if (q.size() >= 30) begin wr = 1'($urandom_range(0, 1)); rd = 1'b1; end
            else begin wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); end
            drive(wr, 8'($urandom_range(0, 255)), rd, 1'b0);
            vectors++;
            if (bus0.fifo_level !== 6'(q.size()))
                begin errors++; $display("FAIL wrap_level got %0d want %0d", bus0.fifo_level, q.size()); end
            if (read_done) begin
                vectors++;
                if (bus0.fifo_rd_data !== exp_rd)
                    begin errors++; $display("FAIL wrap_data got %h want %h", bus0.fifo_rd_data, exp_rd); end
            end
        end
        while (q.size() != 0) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (bus0.fifo_rd_data !== exp_rd)
                begin errors++; $display("FAIL wrap_drain got %h want %h", bus0.fifo_rd_data, exp_rd); end
        end
        vectors++;
        if (bus0.fifo_over !== 1'b0 || bus0.fifo_under !== 1'b0)
            begin errors++; $display("FAIL wrap_errors got %b%b want 00", bus0.fifo_over, bus0.fifo_under); end
    endtask

    task automatic test_fwft_flush();
        bus1.fifo_wren = 1'b1; bus1.fifo_wr_data = 8'h55;
        @(posedge sclk); #1 idle_bus(1'b1);
        vectors += 2;
        if (bus1.fifo_rd_data !== 8'h55) begin errors++; $display("FAIL fwft_data got %h want 55", bus1.fifo_rd_data); end
        if (bus1.fifo_empty !== 1'b0) begin errors++; $display("FAIL fwft_empty got %b want 0", bus1.fifo_empty); end
        bus1.fifo_wren = 1'b1; bus1.fifo_wr_data = 8'h66;
        @(posedge sclk); #1 idle_bus(1'b1);
        bus1.fifo_rden = 1'b1;
        @(posedge sclk); #1 idle_bus(1'b1);
        vectors++;
        if (bus1.fifo_rd_data !== 8'h66) begin errors++; $display("FAIL fwft_pop got %h want 66", bus1.fifo_rd_data); end
        bus1.fifo_flush = 1'b1; bus1.fifo_wren = 1'b1; bus1.fifo_wr_data = 8'h77; bus1.fifo_rden = 1'b1;
        @(posedge sclk); #1 idle_bus(1'b1);
        vectors += 4;
        if (bus1.fifo_level !== 6'd0) begin errors++; $display("FAIL flush_level got %0d want 0", bus1.fifo_level); end
        if (bus1.fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", bus1.fifo_empty); end
        if (bus1.fifo_over !== 1'b0) begin errors++; $display("FAIL flush_over got %b want 0", bus1.fifo_over); end
        if (bus1.fifo_under !== 1'b0) begin errors++; $display("FAIL flush_under got %b want 0", bus1.fifo_under); end
        @(posedge sclk); #1;
        vectors++;
        if (bus1.fifo_level !== 6'd0) begin errors++; $display("FAIL flush_nowrite got %0d want 0", bus1.fifo_level); end
        bus1.fifo_wren = 1'b1; bus1.fifo_wr_data = 8'h99;
        @(posedge sclk); #1 idle_bus(1'b1);
        vectors++;
        if (bus1.fifo_rd_data !== 8'h99) begin errors++; $display("FAIL flush_rewrite got %h want 99", bus1.fifo_rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_fwft_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
